// File: rtl/alu_phase_sequencer.sv
// alu_phase_sequencer: per-instruction controller for the ALU datapath.
// Fetches one instruction word at eip, decodes its opcode byte into length and
// ALU phase count, issues single-cycle phase strobes (phase_4/6/8) each followed
// by a register-writeback slot, then advances eip sequentially or via a branch
// target taken from alu_result.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   run                 level; allows new fetches (sampled in IDLE and ADV only)
//   fetch_ack/data      instruction memory response
//   alu_result          ALU result bus, branch target source
//   fetch_req/addr      fetch request (held until ack), address = eip
//   ope, num_of_ope     latched instruction word and decoded length
//   phase_4/6/8, wb_en  one-cycle ALU phase strobes and writeback enable
//   eip                 current instruction pointer
//   busy, fault         activity flag, sticky fault (illegal opcode / timeout)
//
// Optional feature macro ALU_SEQ_RETIRE_CNT_EN adds retire (pulse in ADV) and
// retire_count[15:0] (wrapping count of retired instructions).
module alu_phase_sequencer #(
  parameter logic [31:0] RESET_EIP     = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  input  logic [31:0] alu_result,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  output logic [31:0] ope,
  output logic [3:0]  num_of_ope,
  output logic        phase_4,
  output logic        phase_6,
  output logic        phase_8,
  output logic        wb_en,
  output logic [31:0] eip,
  output logic        busy,
  output logic        fault
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic        retire,
  output logic [15:0] retire_count
`endif
);

  localparam int unsigned TMO_W    = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, P4, W4, P6, W6, P8, W8, ADV, FAULT
  } state_t;

  state_t state, state_next;

  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       ph_cnt;
  logic             illegal_q;
  logic             branch_q;

  logic [3:0] dec_len;
  logic [1:0] dec_ph;
  logic       dec_legal;
  logic       dec_branch;

  // Opcode decode on the incoming fetch word so length is valid from DECODE on.
  always_comb begin
    dec_len    = 4'd0;
    dec_ph     = 2'd0;
    dec_legal  = 1'b1;
    dec_branch = 1'b0;
    case (fetch_data[31:24])
      8'h55: begin dec_len = 4'd1; dec_ph = 2'd2; end
      8'h89: begin dec_len = 4'd2; dec_ph = 2'd1; end
      8'hb8: begin dec_len = 4'd5; dec_ph = 2'd1; end
      8'h5d: begin dec_len = 4'd1; dec_ph = 2'd2; end
      8'hc3: begin dec_len = 4'd1; dec_ph = 2'd2; dec_branch = 1'b1; end
      8'he8: begin dec_len = 4'd5; dec_ph = 2'd3; dec_branch = 1'b1; end
      8'h6a: begin dec_len = 4'd2; dec_ph = 2'd2; end
      8'h8b: begin dec_len = 4'd3; dec_ph = 2'd2; end
      8'h83: begin dec_len = 4'd3; dec_ph = 2'd1; end
      8'hc9: begin dec_len = 4'd1; dec_ph = 2'd3; end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; an ack in the timeout cycle takes priority over the fault.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = FETCH;
      FETCH: begin
        if (fetch_ack)               state_next = DECODE;
        else if (tmo_cnt == TMO_LAST) state_next = FAULT;
      end
      DECODE:  state_next = illegal_q ? FAULT : P4;
      P4:      state_next = W4;
      W4:      state_next = (ph_cnt >= 2'd2) ? P6 : ADV;
      P6:      state_next = W6;
      W6:      state_next = (ph_cnt == 2'd3) ? P8 : ADV;
      P8:      state_next = W8;
      W8:      state_next = ADV;
      ADV:     state_next = run ? FETCH : IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs track the state being entered; datapath updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      eip        <= RESET_EIP;
      ope        <= '0;
      num_of_ope <= '0;
      ph_cnt     <= '0;
      illegal_q  <= 1'b0;
      branch_q   <= 1'b0;
      tmo_cnt    <= '0;
      fetch_req  <= 1'b0;
      phase_4    <= 1'b0;
      phase_6    <= 1'b0;
      phase_8    <= 1'b0;
      wb_en      <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      fetch_req <= (state_next == FETCH);
      phase_4   <= (state_next == P4);
      phase_6   <= (state_next == P6);
      phase_8   <= (state_next == P8);
      wb_en     <= (state_next == W4) || (state_next == W6) || (state_next == W8);
      busy      <= (state_next != IDLE) && (state_next != FAULT);
      fault     <= (state_next == FAULT);

      tmo_cnt <= (state == FETCH) ? tmo_cnt + TMO_W'(1) : '0;

      if (state == FETCH && fetch_ack) begin
        ope        <= fetch_data;
        num_of_ope <= dec_len;
        ph_cnt     <= dec_ph;
        illegal_q  <= ~dec_legal;
        branch_q   <= dec_branch;
      end

      if (state == ADV) eip <= branch_q ? alu_result : eip + 32'(num_of_ope);
    end
  end

  assign fetch_addr = eip;

`ifdef ALU_SEQ_RETIRE_CNT_EN
  // Retire pulse coincides with ADV; the count steps as ADV completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire       <= 1'b0;
      retire_count <= '0;
    end else begin
      retire <= (state_next == ADV);
      if (state == ADV) retire_count <= retire_count + 16'd1;
    end
  end
`endif

endmodule
